// File: rtl/router_pkg.sv
// Shared constants and helpers for the parametrised router synchronizer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package router_pkg;

    // Largest supported number of output channels
    localparam int MAX_PORTS       = 16;
    // Default watchdog timeout in consecutive unread valid cycles
    localparam int DEFAULT_TIMEOUT = 30;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/router_sync_wdog.sv
// Single-channel read watchdog: pulses soft_reset when a valid FIFO sits unread for TIMEOUT cycles.
// Latency: pulse appears the cycle after the TIMEOUT-th consecutive unread valid cycle; lasts one cycle.
// Backpressure: none; a read or an empty FIFO clears the count immediately.
module router_sync_wdog
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = clog2(DEFAULT_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse_q;
    logic             pulse_d;

    // Count unread valid cycles; on the last one fire the pulse and restart the count
    always_comb begin
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (vld && !rd) begin
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                pulse_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter and registered pulse; reset drops any pending pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign soft_reset = pulse_q;

endmodule

// File: rtl/router_sync_n.sv
// Router synchronizer: latches packet destination, steers write enable, returns full, runs read watchdogs.
// Latency: wr_en/fifo_full/vld_out combinational; addr_err one cycle after detect_addr; soft_reset registered.
// Backpressure: fifo_full of the addressed FIFO goes back to the FSM; invalid addresses report not-full and drop writes.
module router_sync_n
    import router_pkg::*;
#(
    parameter int N_PORTS = 3,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [((clog2(N_PORTS) > 1) ? clog2(N_PORTS) : 1)-1:0] din,
    input  logic                                              detect_addr,
    input  logic                                              wr_en_reg,
    input  logic [N_PORTS-1:0]                                full,
    input  logic [N_PORTS-1:0]                                empty,
    input  logic [N_PORTS-1:0]                                rd_en,
    output logic [N_PORTS-1:0]                                wr_en,
    output logic                                              fifo_full,
    output logic [N_PORTS-1:0]                                vld_out,
    output logic [N_PORTS-1:0]                                soft_reset,
    output logic                                              addr_err
);

    localparam int ADDR_W = (clog2(N_PORTS) > 1) ? clog2(N_PORTS) : 1;
    localparam int CNT_W  = clog2(TIMEOUT + 1);

    localparam bit PORTS_OK   = (N_PORTS >= 2) && (N_PORTS <= MAX_PORTS);
    localparam bit TIMEOUT_OK = (TIMEOUT >= 2) && (TIMEOUT <= 255);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              addr_err_q;
    logic              addr_err_d;

    // Capture a new destination on the header strobe; an address beyond the last port is flagged
    always_comb begin
        addr_d     = addr_q;
        addr_err_d = addr_err_q;
        if (detect_addr) begin
            addr_d     = din;
            addr_err_d = (32'(din) >= 32'(N_PORTS));
        end
    end

    // Address and error registers; soft resets never touch them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            addr_err_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign addr_err = addr_err_q;

    // Decode the latched address into a one-hot write enable and select that FIFO's full flag
    always_comb begin
        wr_en     = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                wr_en[i]  = wr_en_reg & ~addr_err_q;
                fifo_full = full[i] & ~addr_err_q;
            end
        end
    end

    assign vld_out = ~empty;

    // One independent watchdog per output channel
    for (genvar g = 0; g < N_PORTS; g++) begin : g_wdog
        router_sync_wdog #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_wdog (
            .clk        (clk),
            .rst        (rst),
            .vld        (vld_out[g]),
            .rd         (rd_en[g]),
            .soft_reset (soft_reset[g])
        );
    end

    // Parameter legality and write-enable exclusivity
    a_params_legal: assert property (@(posedge clk) disable iff (!rst) (PORTS_OK && TIMEOUT_OK));
    a_wr_en_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(wr_en));

endmodule
